// File: rtl/vrf_read_pkg.sv
// Shared types, sizes and the round-robin pick helper for the multi-channel VRF read front-end.
package vrf_read_pkg;

    localparam int NUM_CH     = 2;
    localparam int DATA_W     = 32;
    localparam int VS_W       = 5;
    localparam int GROUP_W    = 4;
    localparam int SRC_W      = 4;
    localparam int SRC_OUT_W  = 2;
    localparam int INST_W     = 3;
    localparam int READ_LAT   = 2;
    localparam int FIFO_DEPTH = 4;
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [VS_W-1:0]    vs;
        logic               offset;
        logic [GROUP_W-1:0] groupIndex;
        logic [SRC_W-1:0]   readSource;
        logic [INST_W-1:0]  instructionIndex;
    } vrf_read_req_t;

    typedef struct packed {
        logic            valid;
        logic [CH_W-1:0] chan;
    } vrf_read_tag_t;

    // One-hot pick of the first eligible channel at or above ptr, wrapping around.
    function automatic logic [NUM_CH-1:0] rr_pick(input logic [NUM_CH-1:0] eligible,
                                                   input logic [CH_W-1:0]   ptr);
        logic [NUM_CH-1:0] pick;
        logic              found;
        int                idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx       = (int'(ptr) + k) % NUM_CH;
            pick[idx] = eligible[idx] & ~found;
            found     = found | eligible[idx];
        end
        return pick;
    endfunction

endpackage

// File: rtl/vrf_read_pipe_nch_if.sv
// Request, VRF-port and dequeue signals of the VRF read front-end; slave is the front-end side.
interface vrf_read_pipe_nch_if;
    import vrf_read_pkg::*;

    logic [NUM_CH-1:0]         req_valid;
    logic [NUM_CH-1:0]         req_ready;
    logic [NUM_CH*VS_W-1:0]    req_vs;
    logic [NUM_CH-1:0]         req_offset;
    logic [NUM_CH*GROUP_W-1:0] req_group_index;
    logic [NUM_CH*SRC_W-1:0]   req_read_source;
    logic [NUM_CH*INST_W-1:0]  req_inst_index;
    logic                      vrf_req_valid;
    logic                      vrf_req_ready;
    logic [VS_W-1:0]           vrf_req_vs;
    logic [SRC_OUT_W-1:0]      vrf_req_read_source;
    logic                      vrf_req_offset;
    logic [INST_W-1:0]         vrf_req_inst_index;
    logic [DATA_W-1:0]         vrf_read_result;
    logic [NUM_CH-1:0]         deq_valid;
    logic [NUM_CH-1:0]         deq_ready;
    logic [NUM_CH*DATA_W-1:0]  deq_data;

    modport master (
        output req_valid, req_vs, req_offset, req_group_index, req_read_source, req_inst_index,
        input  req_ready,
        input  vrf_req_valid, vrf_req_vs, vrf_req_read_source, vrf_req_offset, vrf_req_inst_index,
        output vrf_req_ready, vrf_read_result,
        input  deq_valid, deq_data,
        output deq_ready
    );

    modport slave (
        input  req_valid, req_vs, req_offset, req_group_index, req_read_source, req_inst_index,
        output req_ready,
        output vrf_req_valid, vrf_req_vs, vrf_req_read_source, vrf_req_offset, vrf_req_inst_index,
        input  vrf_req_ready, vrf_read_result,
        output deq_valid, deq_data,
        input  deq_ready
    );

endinterface

// File: rtl/vrf_read_data_fifo.sv
// Per-channel result FIFO with a registered head (no fall-through); a pop frees a slot for a same-cycle push.
module vrf_read_data_fifo #(
    parameter  int DATA_W     = 32,
    parameter  int FIFO_DEPTH = 4,
    localparam int PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1,
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] data_in,
    input  logic              pop,
    output logic [DATA_W-1:0] data_out,
    output logic              empty,
    output logic              full,
    output logic [CNT_W-1:0]  count
);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wrPtr;
    logic [PTR_W-1:0]  rdPtr;
    logic              doPush;
    logic              doPop;

    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(FIFO_DEPTH));
    assign doPop    = pop & ~empty;
    assign doPush   = push & (~full | doPop);
    assign data_out = mem[rdPtr];

    // Storage array, written on accepted push only.
    always_ff @(posedge clock) begin
        if (doPush) begin
            mem[wrPtr] <= data_in;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clock) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            wrPtr <= doPush ? nextPtr(wrPtr) : wrPtr;
            rdPtr <= doPop  ? nextPtr(rdPtr) : rdPtr;
            case ({doPush, doPop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vrf_read_pipe_nch.sv
// Multi-channel VRF read front-end: credit-gated round-robin issue, return-tag pipeline, per-channel FIFOs.
module vrf_read_pipe_nch
    import vrf_read_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    vrf_read_pipe_nch_if.slave bus,
    output logic               overflow_err
);

    vrf_read_req_t     reqs [NUM_CH];
    vrf_read_req_t     granted;
    vrf_read_tag_t     tagPipe [READ_LAT];
    vrf_read_tag_t     retTag;
    logic [CNT_W-1:0]  occ [NUM_CH];
    logic [CNT_W-1:0]  inflight [NUM_CH];
    logic [CNT_W-1:0]  credit [NUM_CH];
    logic [DATA_W-1:0] fifoData [NUM_CH];
    logic [NUM_CH-1:0] eligible;
    logic [NUM_CH-1:0] grant;
    logic [NUM_CH-1:0] fifoEmpty;
    logic [NUM_CH-1:0] fifoFull;
    logic [NUM_CH-1:0] fifoPush;
    logic [NUM_CH-1:0] fifoPop;
    logic [CH_W-1:0]   rrPtr;
    logic [CH_W-1:0]   grantIdx;
    logic              fire;
    logic              unusedBits;

    // Unpack request buses and gate each channel on its credit; pops this cycle do not add credit.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            reqs[i].vs               = bus.req_vs[i*VS_W +: VS_W];
            reqs[i].offset           = bus.req_offset[i];
            reqs[i].groupIndex       = bus.req_group_index[i*GROUP_W +: GROUP_W];
            reqs[i].readSource       = bus.req_read_source[i*SRC_W +: SRC_W];
            reqs[i].instructionIndex = bus.req_inst_index[i*INST_W +: INST_W];
            credit[i]   = CNT_W'(FIFO_DEPTH) - occ[i] - inflight[i];
            eligible[i] = bus.req_valid[i] & (credit[i] != '0);
        end
        grant = rr_pick(eligible, rrPtr);
    end

    // One-hot grant mux onto the single VRF port.
    always_comb begin
        granted  = '0;
        grantIdx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            granted  = granted  | (reqs[i] & {$bits(vrf_read_req_t){grant[i]}});
            grantIdx = grantIdx | (CH_W'(i) & {CH_W{grant[i]}});
        end
    end

    assign bus.vrf_req_valid       = |eligible;
    assign bus.vrf_req_vs          = granted.vs;
    assign bus.vrf_req_read_source = granted.readSource[SRC_OUT_W-1:0];
    assign bus.vrf_req_offset      = granted.offset;
    assign bus.vrf_req_inst_index  = granted.instructionIndex;
    assign bus.req_ready           = grant & {NUM_CH{bus.vrf_req_ready}};
    assign fire                    = bus.vrf_req_valid & bus.vrf_req_ready;
    assign unusedBits              = ^{granted.groupIndex, granted.readSource[SRC_W-1:SRC_OUT_W]};

    assign retTag        = tagPipe[READ_LAT-1];
    assign bus.deq_valid = ~fifoEmpty;
    assign fifoPop       = bus.deq_valid & bus.deq_ready;

    // Return steering and FIFO head repacking.
    always_comb begin
        bus.deq_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            fifoPush[i] = retTag.valid & (retTag.chan == CH_W'(i));
            bus.deq_data[i*DATA_W +: DATA_W] = fifoData[i];
        end
    end

    // Round-robin pointer moves past the winner only when the VRF takes the request.
    always_ff @(posedge clock) begin
        if (reset) begin
            rrPtr <= '0;
        end else if (fire) begin
            rrPtr <= (grantIdx == CH_W'(NUM_CH - 1)) ? '0 : grantIdx + CH_W'(1);
        end else begin
            rrPtr <= rrPtr;
        end
    end

    // Tag shift register; reset drops every outstanding tag so late VRF data is ignored.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < READ_LAT; k++) begin
                tagPipe[k] <= '{valid: 1'b0, chan: '0};
            end
        end else begin
            tagPipe[0] <= '{valid: fire, chan: grantIdx};
            for (int k = 1; k < READ_LAT; k++) begin
                tagPipe[k] <= tagPipe[k-1];
            end
        end
    end

    // In-flight counters: issue increments, return decrements.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                inflight[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                case ({fire & grant[i], fifoPush[i]})
                    2'b10:   inflight[i] <= inflight[i] + CNT_W'(1);
                    2'b01:   inflight[i] <= inflight[i] - CNT_W'(1);
                    default: inflight[i] <= inflight[i];
                endcase
            end
        end
    end

    // Sticky flag for a return that found no room.
    always_ff @(posedge clock) begin
        if (reset) begin
            overflow_err <= 1'b0;
        end else if (|(fifoPush & fifoFull & ~fifoPop)) begin
            overflow_err <= 1'b1;
        end else begin
            overflow_err <= overflow_err;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : gChan
        vrf_read_data_fifo #(
            .DATA_W    (DATA_W),
            .FIFO_DEPTH(FIFO_DEPTH)
        ) uFifo (
            .clock   (clock),
            .reset   (reset),
            .push    (fifoPush[i]),
            .data_in (bus.vrf_read_result),
            .pop     (fifoPop[i]),
            .data_out(fifoData[i]),
            .empty   (fifoEmpty[i]),
            .full    (fifoFull[i]),
            .count   (occ[i])
        );
    end

endmodule

// File: tb/tb_vrf_read_pipe_nch.sv
// Scoreboard bench for vrf_read_pipe_nch: a VRF model returns tagged data READ_LAT cycles after fire.
module tb_vrf_read_pipe_nch;
    import vrf_read_pkg::*;

    logic clock = 1'b0;
    logic reset;
    logic overflowErr;

    always #5 clock = ~clock;

    vrf_read_pipe_nch_if bus();

    vrf_read_pipe_nch dut (
        .clock       (clock),
        .reset       (reset),
        .bus         (bus),
        .overflow_err(overflowErr)
    );

    typedef struct {
        int                due;
        logic [DATA_W-1:0] data;
    } vrf_ret_t;

    vrf_ret_t          vrfQ [$];
    logic [DATA_W-1:0] expQ [NUM_CH][$];
    int                fireCnt [NUM_CH];
    int                errCnt  = 0;
    int                chkCnt  = 0;
    int                cyc     = 0;
    int                fireSeq = 0;
    int                lastFireCh;
    logic              lastFire;
    logic              lastVrfValid;
    logic [VS_W-1:0]   lastVrfVs;
    logic [NUM_CH-1:0] lastReqReady;
    logic [NUM_CH-1:0] lastDeqValid;
    logic [DATA_W-1:0] lastDeq0Data;

    task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chkCnt++;
        if (got !== exp) begin
            errCnt++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic setFields();
        bus.req_vs          = (NUM_CH*VS_W)'($urandom);
        bus.req_offset      = NUM_CH'($urandom);
        bus.req_group_index = (NUM_CH*GROUP_W)'($urandom);
        bus.req_read_source = (NUM_CH*SRC_W)'($urandom);
        bus.req_inst_index  = (NUM_CH*INST_W)'($urandom);
    endtask

    // Sample at the falling edge, score fires and dequeues, then step past the next rising edge.
    task automatic cycle();
        logic [DATA_W-1:0] d;
        @(negedge clock);
        lastReqReady = bus.req_ready;
        lastDeqValid = bus.deq_valid;
        lastDeq0Data = bus.deq_data[DATA_W-1:0];
        lastVrfValid = bus.vrf_req_valid;
        lastVrfVs    = bus.vrf_req_vs;
        lastFire     = bus.vrf_req_valid & bus.vrf_req_ready;
        if (reset) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                expQ[ch].delete();
                fireCnt[ch] = 0;
            end
        end else begin
            if (lastFire) begin
                checkEq("grantOneHot", 64'($countones(bus.req_ready)), 64'd1);
                lastFireCh = 0;
                for (int ch = 0; ch < NUM_CH; ch++) begin
                    if (bus.req_ready[ch]) lastFireCh = ch;
                end
                fireCnt[lastFireCh]++;
                checkEq("vrfVs", 64'(bus.vrf_req_vs), 64'(bus.req_vs[lastFireCh*VS_W +: VS_W]));
                checkEq("vrfSrc", 64'(bus.vrf_req_read_source),
                        64'(bus.req_read_source[lastFireCh*SRC_W +: SRC_OUT_W]));
                checkEq("vrfOffset", 64'(bus.vrf_req_offset), 64'(bus.req_offset[lastFireCh]));
                checkEq("vrfInst", 64'(bus.vrf_req_inst_index),
                        64'(bus.req_inst_index[lastFireCh*INST_W +: INST_W]));
                fireSeq++;
                d = {16'hA5A5, 16'(fireSeq)};
                vrfQ.push_back('{due: cyc + READ_LAT, data: d});
                expQ[lastFireCh].push_back(d);
            end else begin
                checkEq("readyWithoutFire", 64'(bus.req_ready), 64'd0);
            end
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (bus.deq_valid[ch] && bus.deq_ready[ch]) begin
                    if (expQ[ch].size() == 0) begin
                        checkEq("deqUnexpected", 64'(ch + 1), 64'd0);
                    end else begin
                        checkEq("deqData", 64'(bus.deq_data[ch*DATA_W +: DATA_W]), 64'(expQ[ch].pop_front()));
                    end
                end
            end
        end
        @(posedge clock);
        #1;
        cyc++;
        if (vrfQ.size() > 0 && vrfQ[0].due == cyc) begin
            bus.vrf_read_result = vrfQ[0].data;
            void'(vrfQ.pop_front());
        end else begin
            bus.vrf_read_result = 32'hDEAD_BEEF;
        end
    endtask

    task automatic doReset();
        reset         = 1'b1;
        bus.req_valid = '0;
        repeat (2) cycle();
        reset = 1'b0;
    endtask

    initial begin
        reset               = 1'b1;
        bus.req_valid       = '0;
        bus.deq_ready       = '0;
        bus.vrf_req_ready   = 1'b1;
        bus.vrf_read_result = '0;
        setFields();
        @(posedge clock);
        #1;
        doReset();

        // Reset state
        cycle();
        checkEq("rstDeqValid", 64'(lastDeqValid), 64'd0);
        checkEq("rstVrfValid", 64'(lastVrfValid), 64'd0);
        checkEq("rstReqReady", 64'(lastReqReady), 64'd0);
        checkEq("rstOverflow", 64'(overflowErr), 64'd0);

        // 1: single read latency on ch0
        bus.deq_ready = '1;
        bus.req_valid = 2'b01;
        cycle();
        checkEq("t1Fire", 64'(lastFire), 64'd1);
        checkEq("t1FireCh", 64'(lastFireCh), 64'd0);
        bus.req_valid = '0;
        for (int k = 1; k <= 3; k++) begin
            cycle();
            checkEq("t1DeqValid", 64'(lastDeqValid[0]), 64'(k == 3));
        end
        checkEq("t1Data", 64'(lastDeq0Data), 64'hA5A5_0001);

        // 2: alternating grants
        doReset();
        bus.req_valid = 2'b11;
        for (int i = 0; i < 8; i++) begin
            setFields();
            cycle();
            checkEq("t2Fire", 64'(lastFire), 64'd1);
            checkEq("t2Grant", 64'(lastFireCh), 64'(i % 2));
        end
        bus.req_valid = '0;
        repeat (6) cycle();
        checkEq("t2Drain0", 64'(expQ[0].size()), 64'd0);
        checkEq("t2Drain1", 64'(expQ[1].size()), 64'd0);

        // 3: ch1 consumer stalled, credit limits ch1 to FIFO_DEPTH reads
        doReset();
        bus.deq_ready = 2'b01;
        bus.req_valid = 2'b11;
        repeat (12) cycle();
        checkEq("t3Ch1Issued", 64'(fireCnt[1]), 64'(FIFO_DEPTH));
        checkEq("t3Ch0Issued", 64'(fireCnt[0]), 64'(12 - FIFO_DEPTH));
        checkEq("t3Ch1Blocked", 64'(lastReqReady[1]), 64'd0);
        checkEq("t3Ch1Valid", 64'(lastDeqValid[1]), 64'd1);
        checkEq("t3Overflow", 64'(overflowErr), 64'd0);

        // 4: pop from full ch1 frees credit only on the next cycle
        bus.req_valid = 2'b10;
        bus.deq_ready = 2'b10;
        cycle();
        checkEq("t4SameCycle", 64'(lastReqReady[1]), 64'd0);
        bus.deq_ready = 2'b00;
        cycle();
        checkEq("t4NextCycle", 64'(lastReqReady[1]), 64'd1);
        cycle();
        checkEq("t4Refull", 64'(lastReqReady[1]), 64'd0);
        bus.req_valid = '0;
        bus.deq_ready = '1;
        repeat (10) cycle();
        checkEq("t4Drain0", 64'(expQ[0].size()), 64'd0);
        checkEq("t4Drain1", 64'(expQ[1].size()), 64'd0);
        checkEq("t4Overflow", 64'(overflowErr), 64'd0);

        // 5: VRF stall holds the round-robin state
        doReset();
        bus.req_valid = 2'b11;
        bus.req_vs    = {5'd17, 5'd3};
        cycle();
        checkEq("t5FirstCh", 64'(lastFireCh), 64'd0);
        bus.vrf_req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            checkEq("t5NoFire", 64'(lastFire), 64'd0);
            checkEq("t5HeldVs", 64'(lastVrfVs), 64'd17);
        end
        bus.vrf_req_ready = 1'b1;
        cycle();
        checkEq("t5Release", 64'(lastFire), 64'd1);
        checkEq("t5ReleaseCh", 64'(lastFireCh), 64'd1);
        bus.req_valid = '0;
        repeat (6) cycle();

        // 6: reset with reads in flight
        doReset();
        bus.deq_ready = '0;
        bus.req_valid = 2'b01;
        cycle();
        cycle();
        checkEq("t6Issued", 64'(fireCnt[0]), 64'd2);
        bus.req_valid = '0;
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cycle();
            checkEq("t6NoDeq", 64'(lastDeqValid), 64'd0);
        end
        bus.req_valid = 2'b01;
        repeat (8) cycle();
        checkEq("t6Credit", 64'(fireCnt[0]), 64'(FIFO_DEPTH));
        bus.req_valid = '0;
        bus.deq_ready = '1;
        repeat (8) cycle();
        checkEq("t6Drain", 64'(expQ[0].size()), 64'd0);
        checkEq("t6Overflow", 64'(overflowErr), 64'd0);

        $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
        $finish;
    end

endmodule
